// File: rtl/otp_shadow_ctrl.sv
// OTPROM sequencer: loads a window of fuse words into shadow registers after reset,
// then arbitrates master reads and multi-cycle burns while keeping the shadow coherent.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_LOAD      | issuing shadow-window reads, capturing the previous word
//   S_LOAD_TAIL | capturing the last shadow word, setting load_done
//   S_IDLE      | master port open: reads pass through, burns are latched
//   S_BURN      | holding s_ram_wen for BURN_CYCLES, shadow OR on last cycle
module otp_shadow_ctrl #(
    parameter int                   BUS_WIDTH    = 8,
    parameter int                   DATA_WIDTH   = 32,
    parameter logic [BUS_WIDTH-1:0] SHADOW_BASE  = 'h10,
    parameter int                   SHADOW_WORDS = 4,
    parameter int                   BURN_CYCLES  = 8
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [BUS_WIDTH-1:0]             m_ram_raddr,
    input  logic                             m_ram_ren,
    output logic [DATA_WIDTH-1:0]            m_ram_rdata,
    output logic                             m_rvalid,
    input  logic [BUS_WIDTH-1:0]             m_ram_waddr,
    input  logic [DATA_WIDTH-1:0]            m_ram_wdata,
    input  logic [DATA_WIDTH/8-1:0]          m_ram_wen,
    output logic                             m_ready,
    output logic [BUS_WIDTH-1:0]             s_ram_raddr,
    output logic                             s_ram_ren,
    input  logic [DATA_WIDTH-1:0]            s_ram_rdata,
    output logic [BUS_WIDTH-1:0]             s_ram_waddr,
    output logic [DATA_WIDTH-1:0]            s_ram_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_ram_wen,
    output logic [SHADOW_WORDS*DATA_WIDTH-1:0] shadow_data,
    output logic                             load_done,
    output logic                             secure_debug_disable
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IW    = (SHADOW_WORDS > 1) ? $clog2(SHADOW_WORDS) : 1;
    localparam int BW    = $clog2(BURN_CYCLES + 1);

    localparam logic [IW-1:0]        LAST_IDX  = IW'(SHADOW_WORDS - 1);
    localparam logic [BW-1:0]        BURN_LOAD = BW'(BURN_CYCLES);
    localparam logic [BUS_WIDTH:0]   WIN_LIMIT = (BUS_WIDTH + 1)'(SHADOW_WORDS);

    typedef enum logic [1:0] {
        S_LOAD,
        S_LOAD_TAIL,
        S_IDLE,
        S_BURN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          idx;
    logic [BW-1:0]          bcnt;
    logic [BUS_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [LANES-1:0]       wr_lanes;
    logic [DATA_WIDTH-1:0]  shadow [SHADOW_WORDS];
    logic                   load_done_q;
    logic                   rvalid_q;

    logic                   burn_req;
    logic                   burn_last;
    logic [BUS_WIDTH-1:0]   win_off;
    logic [IW-1:0]          win_idx;
    logic                   in_win;
    logic [DATA_WIDTH-1:0]  lane_mask;

    assign burn_req  = |m_ram_wen;
    assign burn_last = (state == S_BURN) && (bcnt == BW'(1));
    assign win_off   = wr_addr - SHADOW_BASE;
    assign win_idx   = IW'(win_off);
    assign in_win    = {1'b0, win_off} < WIN_LIMIT;

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < LANES; b++) begin
            lane_mask[b*8 +: 8] = {8{wr_lanes[b]}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        s_ram_ren   = 1'b0;
        s_ram_raddr = m_ram_raddr;
        s_ram_wen   = '0;
        m_ready     = 1'b0;
        case (state)
            S_LOAD: begin
                s_ram_ren   = 1'b1;
                s_ram_raddr = SHADOW_BASE + BUS_WIDTH'(idx);
                if (idx == LAST_IDX) begin
                    state_nxt = S_LOAD_TAIL;
                end
            end
            S_LOAD_TAIL: begin
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                m_ready   = 1'b1;
                s_ram_ren = m_ram_ren & ~burn_req;
                if (burn_req) begin
                    state_nxt = S_BURN;
                end
            end
            S_BURN: begin
                s_ram_wen = wr_lanes;
                if (bcnt == BW'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx         <= '0;
            bcnt        <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_lanes    <= '0;
            load_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            for (int k = 0; k < SHADOW_WORDS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            rvalid_q <= (state == S_IDLE) && m_ram_ren && !burn_req;

            if (state == S_LOAD && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end

            if (state == S_LOAD_TAIL) begin
                load_done_q <= 1'b1;
            end

            if (state == S_IDLE && burn_req) begin
                wr_addr  <= m_ram_waddr;
                wr_data  <= m_ram_wdata;
                wr_lanes <= m_ram_wen;
                bcnt     <= BURN_LOAD;
            end else if (state == S_BURN) begin
                bcnt <= bcnt - 1'b1;
            end

            // Array data lags its read by one cycle, so LOAD stores the word issued last cycle.
            for (int k = 0; k < SHADOW_WORDS; k++) begin
                if (state == S_LOAD && k < SHADOW_WORDS - 1 && idx == IW'(k + 1)) begin
                    shadow[k] <= s_ram_rdata;
                end else if (state == S_LOAD_TAIL && k == SHADOW_WORDS - 1) begin
                    shadow[k] <= s_ram_rdata;
                end else if (burn_last && in_win && win_idx == IW'(k)) begin
                    shadow[k] <= shadow[k] | (wr_data & lane_mask);
                end
            end
        end
    end

    for (genvar g = 0; g < SHADOW_WORDS; g++) begin : g_shadow_out
        assign shadow_data[g*DATA_WIDTH +: DATA_WIDTH] = shadow[g];
    end

    assign m_ram_rdata          = s_ram_rdata;
    assign m_rvalid             = rvalid_q;
    assign s_ram_waddr          = wr_addr;
    assign s_ram_wdata          = wr_data;
    assign load_done            = load_done_q;
    assign secure_debug_disable = load_done_q ? shadow[0][0] : 1'b1;

endmodule

// File: tb/tb_otp_shadow_ctrl.sv
// Directed bench for otp_shadow_ctrl: array model, scoreboard for master reads,
// direct checks of load sequencing, burn timing and shadow coherence.
module tb_otp_shadow_ctrl;

    localparam int BUS_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int SW = 4;
    localparam int BC = 8;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic [BUS_WIDTH-1:0]    m_ram_raddr = '0;
    logic                    m_ram_ren = 1'b0;
    logic [DATA_WIDTH-1:0]   m_ram_rdata;
    logic                    m_rvalid;
    logic [BUS_WIDTH-1:0]    m_ram_waddr = '0;
    logic [DATA_WIDTH-1:0]   m_ram_wdata = '0;
    logic [3:0]              m_ram_wen = '0;
    logic                    m_ready;
    logic [BUS_WIDTH-1:0]    s_ram_raddr;
    logic                    s_ram_ren;
    logic [DATA_WIDTH-1:0]   s_ram_rdata = '0;
    logic [BUS_WIDTH-1:0]    s_ram_waddr;
    logic [DATA_WIDTH-1:0]   s_ram_wdata;
    logic [3:0]              s_ram_wen;
    logic [SW*DATA_WIDTH-1:0] shadow_data;
    logic                    load_done;
    logic                    secure_debug_disable;

    otp_shadow_ctrl #(
        .BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SHADOW_BASE(8'h10),
        .SHADOW_WORDS(SW), .BURN_CYCLES(BC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_ram_raddr(m_ram_raddr), .m_ram_ren(m_ram_ren), .m_ram_rdata(m_ram_rdata),
        .m_rvalid(m_rvalid), .m_ram_waddr(m_ram_waddr), .m_ram_wdata(m_ram_wdata),
        .m_ram_wen(m_ram_wen), .m_ready(m_ready), .s_ram_raddr(s_ram_raddr),
        .s_ram_ren(s_ram_ren), .s_ram_rdata(s_ram_rdata), .s_ram_waddr(s_ram_waddr),
        .s_ram_wdata(s_ram_wdata), .s_ram_wen(s_ram_wen), .shadow_data(shadow_data),
        .load_done(load_done), .secure_debug_disable(secure_debug_disable)
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] mem [256];
    always @(posedge clk) begin
        if (s_ram_ren) s_ram_rdata <= mem[s_ram_raddr];
    end

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [SW*DATA_WIDTH-1:0] exp_sh;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Read monitor: every m_rvalid must match the oldest expected read.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (m_rvalid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rvalid_unexpected cycle %0d: got rvalid with data %h, expected none",
                             cyc, m_ram_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_ram_rdata !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL rdata cycle %0d: got %h expected %h in cycle %0d",
                                 cyc, m_ram_rdata, e.data, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic release_and_load(input bit hold_read);
        exp_t e;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc = 0;
        if (hold_read) begin
            m_ram_raddr = 8'h41;
            m_ram_ren   = 1'b1;
        end
        exp_sh = {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]};
        for (int k = 0; k < SW; k++) begin
            chk("load_ren", s_ram_ren, 1);
            chk("load_raddr", s_ram_raddr, 128'(8'h10 + k));
            chk("load_ready", m_ready, 0);
            step();
        end
        chk("tail_ren", s_ram_ren, 0);
        chk("tail_done", load_done, 0);
        chk("tail_sdd", secure_debug_disable, 1);
        step();
        chk("done", load_done, 1);
        chk("ready_after_load", m_ready, 1);
        chk("shadow_after_load", shadow_data, exp_sh);
        chk("sdd_after_load", secure_debug_disable, mem[8'h10][0]);
        if (hold_read) begin
            e.data = mem[8'h41];
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            step();
            m_ram_ren = 1'b0;
        end
    endtask

    task automatic issue_read(input logic [7:0] addr);
        exp_t e;
        chk("read_ready", m_ready, 1);
        m_ram_raddr = addr;
        m_ram_ren   = 1'b1;
        e.data = mem[addr];
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        step();
    endtask

    task automatic do_burn(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] lanes, input bit with_read);
        chk("burn_ready", m_ready, 1);
        m_ram_waddr = addr;
        m_ram_wdata = data;
        m_ram_wen   = lanes;
        if (with_read) begin
            m_ram_raddr = 8'h40;
            m_ram_ren   = 1'b1;
            #1;
            chk("collide_sren", s_ram_ren, 0);
        end
        step();
        m_ram_wen = '0;
        m_ram_ren = 1'b0;
        for (int i = 1; i <= BC; i++) begin
            chk("burn_wen", s_ram_wen, lanes);
            chk("burn_ready_low", m_ready, 0);
            chk("burn_waddr", s_ram_waddr, addr);
            chk("burn_wdata", s_ram_wdata, data);
            step();
        end
        chk("burn_end_ready", m_ready, 1);
        chk("burn_end_wen", s_ram_wen, 0);
        chk("burn_shadow", shadow_data, exp_sh);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[8'h10] = 32'd1;
        mem[8'h11] = 32'd2;
        mem[8'h12] = 32'd3;
        mem[8'h13] = 32'd4;
        mem[8'h40] = 32'hA5;
        mem[8'h41] = 32'h5A;

        step();
        step();
        chk("rst_ready", m_ready, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_done", load_done, 0);
        chk("rst_sdd", secure_debug_disable, 1);
        chk("rst_shadow", shadow_data, 0);
        chk("rst_wen", s_ram_wen, 0);
        chk("rst_waddr", s_ram_waddr, 0);
        chk("rst_wdata", s_ram_wdata, 0);

        release_and_load(1'b0);
        chk("load_shadow_const", shadow_data, 128'h00000004_00000003_00000002_00000001);

        step();
        issue_read(8'h40);
        issue_read(8'h41);
        m_ram_ren = 1'b0;
        step();

        exp_sh[1*32 +: 32] = 32'h0000_00F2;
        do_burn(8'h11, 32'h0F0F_00F0, 4'b0001, 1'b0);
        exp_sh[3*32 +: 32] = 32'hAA00_CC04;
        do_burn(8'h13, 32'hAABB_CCDD, 4'b1010, 1'b0);
        do_burn(8'h14, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        do_burn(8'h0F, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        do_burn(8'h80, 32'h0000_00FF, 4'b0001, 1'b1);
        step();

        // Abort a burn three cycles in.
        mem[8'h10] = 32'd0;
        m_ram_waddr = 8'h12;
        m_ram_wdata = 32'h0000_F000;
        m_ram_wen   = 4'b0010;
        step();
        m_ram_wen = '0;
        step();
        step();
        chk("midburn_wen", s_ram_wen, 4'b0010);
        resetn = 1'b0;
        #1;
        chk("abort_wen", s_ram_wen, 0);
        chk("abort_ready", m_ready, 0);
        chk("abort_done", load_done, 0);
        chk("abort_shadow", shadow_data, 0);
        step();
        release_and_load(1'b1);
        chk("reload_sdd_low", secure_debug_disable, 0);

        exp_sh[0*32 +: 32] = 32'h0000_0001;
        do_burn(8'h10, 32'h0000_0001, 4'b0001, 1'b0);
        chk("sdd_after_burn", secure_debug_disable, 1);

        step();
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
